// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Internal datapath width: one guard bit so unsigned operands survive sign extension.
  function automatic int calc_iw(input int width);
    return width + 1;
  endfunction

  // Iteration counter width: must hold the value IW.
  function automatic int calc_cw(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_mult_dp.sv
// Booth datapath: A/Q/M/Qprev accumulator registers and iteration counter.
// Latency: one register update per control strobe (load, add/sub, shift).
// Backpressure: none; the controlling FSM sequences every strobe.
module booth_mult_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 add_sub_en,
  input  logic                 shift_en,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     num_1,
  input  logic [WIDTH-1:0]     num_2,
  output logic [1:0]           q0_qprev,
  output logic                 count_last,
  output logic [2*WIDTH-1:0]   product
);

  localparam int IW = calc_iw(WIDTH);
  localparam int CW = calc_cw(WIDTH);

  logic [IW-1:0] a_q, a_d;
  logic [IW-1:0] q_q, q_d;
  logic [IW-1:0] m_q, m_d;
  logic          qprev_q, qprev_d;
  logic [CW-1:0] count_q, count_d;

  logic [IW-1:0] m_ext;
  logic [IW-1:0] q_ext;

  // The guard bit copies the msb only for signed operands, so unsigned values stay positive.
  assign m_ext = {signed_mode & num_1[WIDTH-1], num_1};
  assign q_ext = {signed_mode & num_2[WIDTH-1], num_2};

  assign q0_qprev   = {q_q[0], qprev_q};
  assign count_last = (count_q == CW'(1));
  // Low 2*WIDTH bits of {A,Q}; the top two bits of A are only sign copies.
  assign product    = {a_q[WIDTH-2:0], q_q};

  // Next-state selection for the accumulator registers from the FSM strobes.
  always_comb begin
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    qprev_d = qprev_q;
    count_d = count_q;
    if (load) begin
      a_d     = '0;
      m_d     = m_ext;
      q_d     = q_ext;
      qprev_d = 1'b0;
      count_d = CW'(IW);
    end else if (add_sub_en) begin
      // 01 adds M, 10 subtracts M; the FSM only strobes on those two codes.
      if (q0_qprev == 2'b01) begin
        a_d = a_q + m_q;
      end else begin
        a_d = a_q - m_q;
      end
    end else if (shift_en) begin
      a_d     = {a_q[IW-1], a_q[IW-1:1]};
      q_d     = {a_q[0], q_q[IW-1:1]};
      qprev_d = q_q[0];
      count_d = count_q - CW'(1);
    end
  end

  // Datapath register bank, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qprev_q <= 1'b0;
      count_q <= '0;
    end else begin
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qprev_q <= qprev_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
// Latency: ready pulses 2*(WIDTH+1)+1 edges after valid is accepted in IDLE.
// Backpressure: valid is ignored (not queued) while busy; accepted again in the ready cycle.
module booth_mult_param
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     num_1,
  input  logic [WIDTH-1:0]     num_2,
  output logic                 busy,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   mult_result
);

  state_t             state_q, state_d;
  logic               load;
  logic               add_sub_en;
  logic               shift_en;
  logic [1:0]         q0_qprev;
  logic               count_last;
  logic [2*WIDTH-1:0] product;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  booth_mult_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .add_sub_en  (add_sub_en),
    .shift_en    (shift_en),
    .signed_mode (signed_mode),
    .num_1       (num_1),
    .num_2       (num_2),
    .q0_qprev    (q0_qprev),
    .count_last  (count_last),
    .product     (product)
  );

  // FSM next state, datapath strobes and result capture.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    add_sub_en = 1'b0;
    shift_en   = 1'b0;
    ready_d    = 1'b0;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          load    = 1'b1;
          state_d = EVAL;
        end
      end
      EVAL: begin
        // 00 and 11 leave A unchanged, so no strobe is needed for them.
        add_sub_en = q0_qprev[1] ^ q0_qprev[0];
        state_d    = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        state_d  = count_last ? DONE : EVAL;
      end
      DONE: begin
        result_d = product;
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation without a ready pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign ready       = ready_q;
  assign mult_result = result_q;

endmodule

// File: tb/tb_booth_mult_param.sv
// Directed and random checks of booth_mult_param at WIDTH 8, 4 and 16.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_booth_mult_param;

  logic clk;
  logic reset;

  logic        valid8, sm8, busy8, ready8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  logic        valid4, sm4, busy4, ready4;
  logic [3:0]  a4, b4;
  logic [7:0]  res4;

  logic        valid16, sm16, busy16, ready16;
  logic [15:0] a16, b16;
  logic [31:0] res16;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp8[$];
  logic [31:0] exp4[$];
  logic [31:0] exp16[$];

  booth_mult_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .valid(valid8), .signed_mode(sm8),
    .num_1(a8), .num_2(b8), .busy(busy8), .ready(ready8), .mult_result(res8)
  );

  booth_mult_param #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .valid(valid4), .signed_mode(sm4),
    .num_1(a4), .num_2(b4), .busy(busy4), .ready(ready4), .mult_result(res4)
  );

  booth_mult_param #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .valid(valid16), .signed_mode(sm16),
    .num_1(a16), .num_2(b16), .busy(busy16), .ready(ready16), .mult_result(res16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product, truncated to 2*w bits.
  function automatic logic [31:0] refm(input int w, input bit sm,
                                       input logic [31:0] a, input logic [31:0] b);
    longint x, y, p, mask;
    mask = (longint'(1) << w) - 1;
    x = longint'(a) & mask;
    y = longint'(b) & mask;
    if (sm && x[w-1]) x = x - (longint'(1) << w);
    if (sm && y[w-1]) y = y - (longint'(1) << w);
    p = (x * y) & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present one operation for a single cycle and queue its expected product.
  task automatic start(input int w, input bit sm, input logic [31:0] a, input logic [31:0] b);
    case (w)
      4: begin
        valid4 = 1'b1; sm4 = sm; a4 = a[3:0]; b4 = b[3:0];
        exp4.push_back(refm(4, sm, a, b));
      end
      16: begin
        valid16 = 1'b1; sm16 = sm; a16 = a[15:0]; b16 = b[15:0];
        exp16.push_back(refm(16, sm, a, b));
      end
      default: begin
        valid8 = 1'b1; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
        exp8.push_back(refm(8, sm, a, b));
      end
    endcase
    @(posedge clk); #1;
    valid4 = 1'b0; valid8 = 1'b0; valid16 = 1'b0;
  endtask

  // Wait (bounded) for ready, check latency and pop/compare the scoreboard.
  task automatic wait_ready(input int w, input int lat, input string tag);
    int n;
    bit got;
    logic [31:0] r, e;
    got = 1'b0;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      n = i;
      if ((w == 4 && ready4) || (w == 16 && ready16) || (w == 8 && ready8)) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, " ready_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, " latency"}, 32'(n), 32'(lat));
      r = (w == 4) ? 32'(res4) : (w == 16) ? res16 : 32'(res8);
      if (w == 4) e = (exp4.size() > 0) ? exp4.pop_front() : 32'hDEAD_BEEF;
      else if (w == 16) e = (exp16.size() > 0) ? exp16.pop_front() : 32'hDEAD_BEEF;
      else e = (exp8.size() > 0) ? exp8.pop_front() : 32'hDEAD_BEEF;
      check({tag, " result"}, r, e);
    end
  endtask

  initial begin
    bit saw_ready;
    logic [31:0] ra, rb;
    bit rsm;

    reset = 1'b0;
    valid8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    valid4 = 0; sm4 = 0; a4 = 0; b4 = 0;
    valid16 = 0; sm16 = 0; a16 = 0; b16 = 0;

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy8), 32'd0);
    check("reset ready", 32'(ready8), 32'd0);
    check("reset result", 32'(res8), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Signed 7 * -3, then confirm the ready pulse is one cycle wide.
    start(8, 1'b1, 32'd7, 32'hFD);
    check("busy after accept", 32'(busy8), 32'd1);
    wait_ready(8, 19, "s7xm3");
    check("s7xm3 value", 32'(res8), 32'hFFEB);
    check("s7xm3 busy in ready cycle", 32'(busy8), 32'd0);
    @(posedge clk); #1;
    check("ready one cycle", 32'(ready8), 32'd0);
    check("busy low after", 32'(busy8), 32'd0);

    start(8, 1'b1, 32'h80, 32'h80);
    wait_ready(8, 19, "s_min_min");
    check("s_min_min value", 32'(res8), 32'h4000);
    start(8, 1'b1, 32'hFF, 32'hFF);
    wait_ready(8, 19, "s_m1_m1");
    check("s_m1_m1 value", 32'(res8), 32'h0001);
    start(8, 1'b0, 32'hFF, 32'hFF);
    wait_ready(8, 19, "u_ff_ff");
    check("u_ff_ff value", 32'(res8), 32'hFE01);
    start(8, 1'b0, 32'h00, 32'hAB);
    wait_ready(8, 19, "u_0_ab");

    // 12*10 unsigned with stray valid pulses (sampled at edges 5 and 10) that must be ignored.
    start(8, 1'b0, 32'd12, 32'd10);
    saw_ready = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (ready8) begin
        saw_ready = 1'b1;
        check("12x10 latency", 32'(n), 32'd19);
        break;
      end
      if (n == 10) check("busy during op", 32'(busy8), 32'd1);
      if (n == 4 || n == 9) begin
        valid8 = 1'b1; sm8 = 1'b0; a8 = 8'd3; b8 = 8'd3;
      end else begin
        valid8 = 1'b0;
      end
    end
    check("12x10 ready_seen", 32'(saw_ready), 32'd1);
    check("12x10 result", 32'(res8), 32'h0078);
    check("12x10 scoreboard", exp8.pop_front(), 32'h0078);
    check("stray valid not queued", 32'(exp8.size()), 32'd0);

    // Back-to-back: valid in the ready cycle is accepted.
    start(8, 1'b0, 32'd3, 32'd3);
    check("b2b accepted", 32'(busy8), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("b2b old result held", 32'(res8), 32'h0078);
    wait_ready(8, 9, "b2b 3x3");

    // Reset at cycle 8 of an operation clears everything asynchronously.
    start(8, 1'b1, 32'd9, 32'd9);
    void'(exp8.pop_back());
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midreset busy", 32'(busy8), 32'd0);
    check("midreset ready", 32'(ready8), 32'd0);
    check("midreset result", 32'(res8), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    saw_ready = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (ready8) saw_ready = 1'b1;
    end
    check("no ready after abort", 32'(saw_ready), 32'd0);
    start(8, 1'b0, 32'd5, 32'd5);
    wait_ready(8, 19, "after reset 5x5");
    check("5x5 value", 32'(res8), 32'h0019);

    // Narrow and wide builds against the reference model.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rb = $urandom; rsm = 1'($urandom_range(0, 1));
      if (i == 0) begin rsm = 1'b1; ra = 32'h8; rb = 32'h8; end
      if (i == 1) begin rsm = 1'b0; ra = 32'hF; rb = 32'hF; end
      start(4, rsm, ra, rb);
      wait_ready(4, 11, "w4 rand");
    end
    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rb = $urandom; rsm = 1'($urandom_range(0, 1));
      if (i == 0) begin rsm = 1'b1; ra = 32'h8000; rb = 32'h8000; end
      if (i == 1) begin rsm = 1'b0; ra = 32'hFFFF; rb = 32'hFFFF; end
      start(16, rsm, ra, rb);
      wait_ready(16, 35, "w16 rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
